// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor resolving CHUNK bits per register stage.
// Optional signed saturation on the result when PIPE_ADDSUB_SAT_EN is defined.
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  logic             en;

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             cy_q    [STAGES];
  logic             ovf_q   [STAGES];

  logic             valid_d [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic             cy_d    [STAGES];
  logic             ovf_d   [STAGES];

  logic [CHUNK:0]   res     [STAGES];

  // The whole pipeline advances together, so a stalled output freezes every stage.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_sum;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic             src_cy;

      if (gi == 0) begin : g_head
        // Subtraction is A + ~B + 1; the +1 rides on the stage-0 carry-in.
        assign src_valid = in_valid;
        assign src_sum   = '0;
        assign src_a     = a;
        assign src_b     = sub ? ~b : b;
        assign src_cy    = sub | c_in;
      end else begin : g_body
        assign src_valid = valid_q[gi-1];
        assign src_sum   = sum_q[gi-1];
        assign src_a     = a_q[gi-1];
        assign src_b     = b_q[gi-1];
        assign src_cy    = cy_q[gi-1];
      end

      assign res[gi] = {1'b0, src_a[gi*CHUNK +: CHUNK]}
                     + {1'b0, src_b[gi*CHUNK +: CHUNK]}
                     + (CHUNK+1)'(src_cy);

      assign valid_d[gi] = src_valid;
      assign a_d[gi]     = src_a;
      assign b_d[gi]     = src_b;
      assign cy_d[gi]    = res[gi][CHUNK];
      assign sum_d[gi]   = (src_sum & ~(CMASK << (gi*CHUNK)))
                         | (WIDTH'(res[gi][CHUNK-1:0]) << (gi*CHUNK));
      // Carry into the chunk MSB recovered as a ^ b ^ s at that bit; meaningful only in the top stage.
      assign ovf_d[gi]   = res[gi][CHUNK]
                         ^ src_a[gi*CHUNK+CHUNK-1]
                         ^ src_b[gi*CHUNK+CHUNK-1]
                         ^ res[gi][CHUNK-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        cy_q[k]    <= 1'b0;
        ovf_q[k]   <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        cy_q[k]    <= cy_d[k];
        ovf_q[k]   <= ovf_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign c_out     = cy_q[LAST];
  assign ovf       = ovf_q[LAST];

`ifdef PIPE_ADDSUB_SAT_EN
  // A wrapped MSB of 1 on overflow means the true result was positive, and vice versa.
  assign sum = ovf_q[LAST] ? {~sum_q[LAST][WIDTH-1], {(WIDTH-1){sum_q[LAST][WIDTH-1]}}}
                           : sum_q[LAST];
`else
  assign sum = sum_q[LAST];
`endif

endmodule
